sc_scbc_axi_regif: RTL and testbench

SC_SCBC_AXI_REGIF -- requirements
Module: sc_scbc_axi_regif

---
 rtl/sc_scbc_reg_pkg.sv | 27 ++
 rtl/sc_scbc_axi_regif.sv | 233 +++++++++++++++++++++++
 tb/tb_sc_scbc_axi_regif.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_scbc_reg_pkg.sv
// -----------------------------------------------------------------------------
// sc_scbc_reg_pkg
// Shared types and constants for the AXI4-Lite to register-bus bridge.
//   w_state_e   : write-channel FSM states
//   r_state_e   : read-channel FSM states
//   RESP_OKAY   : AXI OKAY response code
//   RESP_SLVERR : AXI SLVERR response code
// -----------------------------------------------------------------------------
package sc_scbc_reg_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REG  = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_REG  = 2'd1,
      R_WAIT = 2'd2,
      R_RESP = 2'd3
   } r_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : sc_scbc_reg_pkg

// File: rtl/sc_scbc_axi_regif.sv
// -----------------------------------------------------------------------------
// sc_scbc_axi_regif
// AXI4-Lite slave that forwards single transfers onto a simple synchronous
// register bus. One write and one read may be in flight at the same time;
// the two channels are independent FSMs.
//
// Ports
//   SYSCLK, SYSRSTB          : clock (rising edge), async active-low reset
//   S_AW*, S_W*, S_B*        : AXI4-Lite write address / data / response
//   S_AR*, S_R*              : AXI4-Lite read address / data
//   REG_WADR/WDAT/WENB       : register-bus write request (byte enables)
//   REG_WWAT, REG_WERR       : write wait-state and error from the slave
//   REG_RADR/RENB            : register-bus read request (one-cycle strobe)
//   REG_RDAT/RWAT/RERR       : read data, wait-state and error from the slave
//   o_dbg_wstate/o_dbg_rstate: current FSM states, for observation only
//
// Handshakes: every AXI channel transfers on a rising edge where VALID and
// READY are both high. A VALID, once raised by this block, stays high with
// stable payload until its READY is seen. All READY/VALID outputs here are
// registered.
// -----------------------------------------------------------------------------
module sc_scbc_axi_regif
   import sc_scbc_reg_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  SYSCLK,
   input  logic                  SYSRSTB,
   // AXI write address
   input  logic [ADDR_WIDTH-1:0] S_AWADDR,
   input  logic                  S_AWVALID,
   output logic                  S_AWREADY,
   // AXI write data
   input  logic [31:0]           S_WDATA,
   input  logic [3:0]            S_WSTRB,
   input  logic                  S_WVALID,
   output logic                  S_WREADY,
   // AXI write response
   output logic [1:0]            S_BRESP,
   output logic                  S_BVALID,
   input  logic                  S_BREADY,
   // AXI read
   input  logic [ADDR_WIDTH-1:0] S_ARADDR,
   input  logic                  S_ARVALID,
   output logic                  S_ARREADY,
   output logic [31:0]           S_RDATA,
   output logic [1:0]            S_RRESP,
   output logic                  S_RVALID,
   input  logic                  S_RREADY,
   // register-bus write
   output logic [ADDR_WIDTH-1:0] REG_WADR,
   output logic [31:0]           REG_WDAT,
   output logic [3:0]            REG_WENB,
   input  logic                  REG_WWAT,
   input  logic                  REG_WERR,
   // register-bus read
   output logic [ADDR_WIDTH-1:0] REG_RADR,
   output logic                  REG_RENB,
   input  logic [31:0]           REG_RDAT,
   input  logic                  REG_RWAT,
   input  logic                  REG_RERR,
   // state observation
   output w_state_e              o_dbg_wstate,
   output r_state_e              o_dbg_rstate
);

   // ---------------------------------------------------------------- write --
   w_state_e              r_wstate;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_aw_got;
   logic                  r_w_got;
   logic [ADDR_WIDTH-1:0] r_wadr;
   logic [31:0]           r_wdat;
   logic [3:0]            r_wstrb;
   logic [3:0]            r_wenb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_both;
   logic [3:0]            w_strb_sel;

   assign w_aw_hs    = S_AWVALID & r_awready;
   assign w_w_hs     = S_WVALID & r_wready;
   // Both halves are present once each has either been captured earlier or
   // is being captured on this edge; AW and W may arrive in any order.
   assign w_both     = (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
   assign w_strb_sel = w_w_hs ? S_WSTRB : r_wstrb;

   always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_aw_got  <= 1'b0;
         r_w_got   <= 1'b0;
         r_wadr    <= '0;
         r_wdat    <= '0;
         r_wstrb   <= '0;
         r_wenb    <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_wadr   <= S_AWADDR;
                  r_aw_got <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wdat   <= S_WDATA;
                  r_wstrb  <= S_WSTRB;
                  r_w_got  <= 1'b1;
               end
               if (w_both) begin
                  r_aw_got  <= 1'b0;
                  r_w_got   <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  // An all-zero strobe touches no byte: answer at once.
                  if (w_strb_sel == 4'h0) begin
                     r_bresp  <= RESP_OKAY;
                     r_bvalid <= 1'b1;
                     r_wstate <= W_RESP;
                  end else begin
                     r_wenb   <= w_strb_sel;
                     r_wstate <= W_REG;
                  end
               end else begin
                  // Each ready drops after its own capture; this also raises
                  // both readies on the first edge after reset.
                  r_awready <= ~(r_aw_got | w_aw_hs);
                  r_wready  <= ~(r_w_got | w_w_hs);
               end
            end
            W_REG: begin
               if (!REG_WWAT) begin
                  r_wenb   <= 4'h0;
                  r_bresp  <= REG_WERR ? RESP_SLVERR : RESP_OKAY;
                  r_bvalid <= 1'b1;
                  r_wstate <= W_RESP;
               end
            end
            W_RESP: begin
               if (S_BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------------- read --
   r_state_e              r_rstate;
   logic                  r_arready;
   logic [ADDR_WIDTH-1:0] r_radr;
   logic                  r_renb;
   logic [31:0]           r_rdata;
   logic [1:0]            r_rresp;
   logic                  r_rvalid;

   always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_radr    <= '0;
         r_renb    <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rvalid  <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (S_ARVALID && r_arready) begin
                  r_radr    <= S_ARADDR;
                  r_arready <= 1'b0;
                  r_renb    <= 1'b1;
                  r_rstate  <= R_REG;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_REG: begin
               // Strobe lasts exactly this one cycle.
               r_renb   <= 1'b0;
               r_rstate <= R_WAIT;
            end
            R_WAIT: begin
               if (!REG_RWAT) begin
                  r_rdata  <= REG_RDAT;
                  r_rresp  <= REG_RERR ? RESP_SLVERR : RESP_OKAY;
                  r_rvalid <= 1'b1;
                  r_rstate <= R_RESP;
               end
            end
            R_RESP: begin
               if (S_RREADY) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs --
   assign S_AWREADY    = r_awready;
   assign S_WREADY     = r_wready;
   assign S_BVALID     = r_bvalid;
   assign S_BRESP      = r_bresp;
   assign REG_WADR     = r_wadr;
   assign REG_WDAT     = r_wdat;
   assign REG_WENB     = r_wenb;

   assign S_ARREADY    = r_arready;
   assign S_RVALID     = r_rvalid;
   assign S_RDATA      = r_rdata;
   assign S_RRESP      = r_rresp;
   assign REG_RADR     = r_radr;
   assign REG_RENB     = r_renb;

   assign o_dbg_wstate = r_wstate;
   assign o_dbg_rstate = r_rstate;

endmodule : sc_scbc_axi_regif

// File: tb/tb_sc_scbc_axi_regif.sv
// -----------------------------------------------------------------------------
// tb_sc_scbc_axi_regif
// Directed bench for sc_scbc_axi_regif: write and read paths, wait states,
// error responses, zero-strobe writes, concurrent traffic with stalled
// response channels, and reset in the middle of transfers.
// -----------------------------------------------------------------------------
module tb_sc_scbc_axi_regif;
   import sc_scbc_reg_pkg::*;

   localparam int AW = 32;

   // ------------------------------------------------------- clock / reset --
   logic          clk;
   logic          rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------ DUT nets --
   logic [AW-1:0] S_AWADDR;
   logic          S_AWVALID, S_AWREADY;
   logic [31:0]   S_WDATA;
   logic [3:0]    S_WSTRB;
   logic          S_WVALID, S_WREADY;
   logic [1:0]    S_BRESP;
   logic          S_BVALID, S_BREADY;
   logic [AW-1:0] S_ARADDR;
   logic          S_ARVALID, S_ARREADY;
   logic [31:0]   S_RDATA;
   logic [1:0]    S_RRESP;
   logic          S_RVALID, S_RREADY;
   logic [AW-1:0] REG_WADR;
   logic [31:0]   REG_WDAT;
   logic [3:0]    REG_WENB;
   logic          REG_WWAT, REG_WERR;
   logic [AW-1:0] REG_RADR;
   logic          REG_RENB;
   logic [31:0]   REG_RDAT;
   logic          REG_RWAT, REG_RERR;
   w_state_e      dbg_w;
   r_state_e      dbg_r;

   sc_scbc_axi_regif #(.ADDR_WIDTH(AW)) dut (
      .SYSCLK       (clk),
      .SYSRSTB      (rst_n),
      .S_AWADDR     (S_AWADDR),
      .S_AWVALID    (S_AWVALID),
      .S_AWREADY    (S_AWREADY),
      .S_WDATA      (S_WDATA),
      .S_WSTRB      (S_WSTRB),
      .S_WVALID     (S_WVALID),
      .S_WREADY     (S_WREADY),
      .S_BRESP      (S_BRESP),
      .S_BVALID     (S_BVALID),
      .S_BREADY     (S_BREADY),
      .S_ARADDR     (S_ARADDR),
      .S_ARVALID    (S_ARVALID),
      .S_ARREADY    (S_ARREADY),
      .S_RDATA      (S_RDATA),
      .S_RRESP      (S_RRESP),
      .S_RVALID     (S_RVALID),
      .S_RREADY     (S_RREADY),
      .REG_WADR     (REG_WADR),
      .REG_WDAT     (REG_WDAT),
      .REG_WENB     (REG_WENB),
      .REG_WWAT     (REG_WWAT),
      .REG_WERR     (REG_WERR),
      .REG_RADR     (REG_RADR),
      .REG_RENB     (REG_RENB),
      .REG_RDAT     (REG_RDAT),
      .REG_RWAT     (REG_RWAT),
      .REG_RERR     (REG_RERR),
      .o_dbg_wstate (dbg_w),
      .o_dbg_rstate (dbg_r)
   );

   // --------------------------------------------------------- scoreboard --
   int            n_vec;
   int            n_err;
   int            wenb_cyc;
   int            renb_cyc;
   int            w0;
   int            r0;
   logic [31:0]   exp_q[$];

   // Strobe-cycle counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (REG_WENB != 4'h0) wenb_cyc++;
         if (REG_RENB) renb_cyc++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rdata(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: observed read data %0h with no expected entry", tag, S_RDATA);
      end else begin
         e = exp_q.pop_front();
         chk(tag, S_RDATA, e);
      end
   endtask

   // -------------------------------------------------------------- driver --
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      S_AWADDR  = '0; S_AWVALID = 1'b0;
      S_WDATA   = '0; S_WSTRB   = 4'h0; S_WVALID = 1'b0;
      S_BREADY  = 1'b0;
      S_ARADDR  = '0; S_ARVALID = 1'b0;
      S_RREADY  = 1'b0;
      REG_WWAT  = 1'b0; REG_WERR = 1'b0;
      REG_RDAT  = '0;   REG_RWAT = 1'b0; REG_RERR = 1'b0;
   endtask

   task automatic drive_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      S_AWADDR = a; S_AWVALID = 1'b1;
      S_WDATA  = d; S_WSTRB   = s; S_WVALID = 1'b1;
   endtask

   task automatic b_handshake(input string tag);
      S_BREADY = 1'b1;
      tick();
      S_BREADY = 1'b0;
      chk({tag, "_bvalid_done"}, S_BVALID, 1'b0);
      chk({tag, "_awready_back"}, S_AWREADY, 1'b1);
   endtask

   task automatic r_handshake(input string tag);
      S_RREADY = 1'b1;
      tick();
      S_RREADY = 1'b0;
      chk({tag, "_rvalid_done"}, S_RVALID, 1'b0);
      chk({tag, "_arready_back"}, S_ARREADY, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_awready"}, S_AWREADY, 1'b0);
      chk({tag, "_wready"},  S_WREADY,  1'b0);
      chk({tag, "_arready"}, S_ARREADY, 1'b0);
      chk({tag, "_bvalid"},  S_BVALID,  1'b0);
      chk({tag, "_rvalid"},  S_RVALID,  1'b0);
      chk({tag, "_renb"},    REG_RENB,  1'b0);
      chk({tag, "_wenb"},    REG_WENB,  4'h0);
      chk({tag, "_bresp"},   S_BRESP,   2'b00);
      chk({tag, "_rresp"},   S_RRESP,   2'b00);
      chk({tag, "_rdata"},   S_RDATA,   32'h0);
      chk({tag, "_wadr"},    REG_WADR,  32'h0);
      chk({tag, "_radr"},    REG_RADR,  32'h0);
      chk({tag, "_wdat"},    REG_WDAT,  32'h0);
   endtask

   // ------------------------------------------------------------ sequence --
   initial begin
      n_vec = 0; n_err = 0; wenb_cyc = 0; renb_cyc = 0; w0 = 0; r0 = 0;
      idle_inputs();
      rst_n = 1'b0;

      // Reset values, then readies on the first edge after release.
      repeat (3) @(posedge clk);
      #1;
      check_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_awready", S_AWREADY, 1'b1);
      chk("post_rst_wready",  S_WREADY,  1'b1);
      chk("post_rst_arready", S_ARREADY, 1'b1);
      chk("post_rst_wstate",  dbg_w, W_IDLE);
      chk("post_rst_rstate",  dbg_r, R_IDLE);

      // AW at cycle 0, W at cycle 3, no wait states.
      w0 = wenb_cyc;
      S_AWADDR = 32'h10; S_AWVALID = 1'b1;
      tick();
      S_AWVALID = 1'b0;
      chk("w1_awready_low", S_AWREADY, 1'b0);
      chk("w1_wready_high", S_WREADY,  1'b1);
      chk("w1_wstate_idle", dbg_w, W_IDLE);
      tick();
      tick();
      S_WDATA = 32'hA5A5_5A5A; S_WSTRB = 4'hF; S_WVALID = 1'b1;
      tick();
      S_WVALID = 1'b0;
      chk("w1_wstate_reg", dbg_w, W_REG);
      chk("w1_wenb",  REG_WENB, 4'hF);
      chk("w1_wadr",  REG_WADR, 32'h10);
      chk("w1_wdat",  REG_WDAT, 32'hA5A5_5A5A);
      chk("w1_wready_low", S_WREADY, 1'b0);
      chk("w1_no_bvalid", S_BVALID, 1'b0);
      tick();
      chk("w1_wenb_off", REG_WENB, 4'h0);
      chk("w1_bvalid", S_BVALID, 1'b1);
      chk("w1_bresp",  S_BRESP, 2'b00);
      tick();
      chk("w1_bvalid_held", S_BVALID, 1'b1);
      chk("w1_wenb_cycles", wenb_cyc - w0, 1);
      b_handshake("w1");

      // Write stalled by REG_WWAT for 5 cycles.
      w0 = wenb_cyc;
      REG_WWAT = 1'b1;
      drive_write(32'h20, 32'hDEAD_BEEF, 4'h3);
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("w2_wenb_hold", REG_WENB, 4'h3);
         chk("w2_wadr_hold", REG_WADR, 32'h20);
         chk("w2_wdat_hold", REG_WDAT, 32'hDEAD_BEEF);
         chk("w2_no_bvalid", S_BVALID, 1'b0);
         tick();
      end
      chk("w2_wenb_last", REG_WENB, 4'h3);
      REG_WWAT = 1'b0;
      tick();
      chk("w2_wenb_off", REG_WENB, 4'h0);
      chk("w2_bvalid", S_BVALID, 1'b1);
      chk("w2_bresp",  S_BRESP, 2'b00);
      chk("w2_wenb_cycles", wenb_cyc - w0, 6);
      b_handshake("w2");

      // Zero strobe goes straight to the response.
      w0 = wenb_cyc;
      drive_write(32'h40, 32'hFFFF_FFFF, 4'h0);
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      chk("w3_wstate_resp", dbg_w, W_RESP);
      chk("w3_bvalid", S_BVALID, 1'b1);
      chk("w3_bresp",  S_BRESP, 2'b00);
      chk("w3_wenb",   REG_WENB, 4'h0);
      chk("w3_wadr",   REG_WADR, 32'h40);
      tick();
      chk("w3_wenb_cycles", wenb_cyc - w0, 0);
      b_handshake("w3");

      // Register slave flags an error.
      REG_WERR = 1'b1;
      drive_write(32'h44, 32'h0000_00FF, 4'h1);
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      chk("w4_wenb", REG_WENB, 4'h1);
      tick();
      REG_WERR = 1'b0;
      chk("w4_bvalid", S_BVALID, 1'b1);
      chk("w4_bresp",  S_BRESP, 2'b10);
      b_handshake("w4");

      // Read with minimum latency.
      r0 = renb_cyc;
      REG_RDAT = 32'h1234_5678;
      exp_q.push_back(32'h1234_5678);
      S_ARADDR = 32'h04; S_ARVALID = 1'b1;
      tick();
      S_ARVALID = 1'b0;
      chk("r1_renb", REG_RENB, 1'b1);
      chk("r1_radr", REG_RADR, 32'h04);
      chk("r1_arready_low", S_ARREADY, 1'b0);
      chk("r1_rstate_reg", dbg_r, R_REG);
      tick();
      chk("r1_renb_off", REG_RENB, 1'b0);
      chk("r1_rstate_wait", dbg_r, R_WAIT);
      chk("r1_radr_wait", REG_RADR, 32'h04);
      chk("r1_no_rvalid", S_RVALID, 1'b0);
      tick();
      REG_RDAT = 32'h0;
      chk("r1_rvalid", S_RVALID, 1'b1);
      chk("r1_rresp",  S_RRESP, 2'b00);
      chk_rdata("r1_rdata");
      tick();
      chk("r1_rvalid_held", S_RVALID, 1'b1);
      chk("r1_rdata_held", S_RDATA, 32'h1234_5678);
      chk("r1_renb_cycles", renb_cyc - r0, 1);
      r_handshake("r1");

      // Read stalled 10 cycles, error on release.
      r0 = renb_cyc;
      REG_RWAT = 1'b1;
      REG_RDAT = 32'hCAFE_F00D;
      exp_q.push_back(32'hCAFE_F00D);
      S_ARADDR = 32'h08; S_ARVALID = 1'b1;
      tick();
      S_ARVALID = 1'b0;
      tick();
      repeat (10) tick();
      chk("r2_rstate_wait", dbg_r, R_WAIT);
      chk("r2_no_rvalid", S_RVALID, 1'b0);
      chk("r2_radr_wait", REG_RADR, 32'h08);
      REG_RWAT = 1'b0; REG_RERR = 1'b1;
      tick();
      REG_RERR = 1'b0; REG_RDAT = 32'h0;
      chk("r2_rvalid", S_RVALID, 1'b1);
      chk("r2_rresp",  S_RRESP, 2'b10);
      chk_rdata("r2_rdata");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("r2_rvalid_held", S_RVALID, 1'b1);
         chk("r2_rresp_held",  S_RRESP, 2'b10);
         chk("r2_rdata_held",  S_RDATA, 32'hCAFE_F00D);
      end
      chk("r2_renb_cycles", renb_cyc - r0, 1);
      r_handshake("r2");

      // Concurrent write and read with both response channels stalled.
      w0 = wenb_cyc; r0 = renb_cyc;
      drive_write(32'h30, 32'h1111_2222, 4'hF);
      S_ARADDR = 32'h0C; S_ARVALID = 1'b1;
      REG_RDAT = 32'h0BAD_F00D;
      exp_q.push_back(32'h0BAD_F00D);
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
      chk("c_wstate_reg", dbg_w, W_REG);
      chk("c_rstate_reg", dbg_r, R_REG);
      tick();
      chk("c_bvalid", S_BVALID, 1'b1);
      tick();
      chk("c_rvalid", S_RVALID, 1'b1);
      chk_rdata("c_rdata");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("c_bvalid_held", S_BVALID, 1'b1);
         chk("c_rvalid_held", S_RVALID, 1'b1);
         chk("c_bresp_held",  S_BRESP, 2'b00);
         chk("c_rdata_held",  S_RDATA, 32'h0BAD_F00D);
         chk("c_no_wenb",     REG_WENB, 4'h0);
         chk("c_no_renb",     REG_RENB, 1'b0);
      end
      chk("c_wenb_cycles", wenb_cyc - w0, 1);
      chk("c_renb_cycles", renb_cyc - r0, 1);
      S_BREADY = 1'b1; S_RREADY = 1'b1;
      tick();
      S_BREADY = 1'b0; S_RREADY = 1'b0;
      chk("c_bvalid_done", S_BVALID, 1'b0);
      chk("c_rvalid_done", S_RVALID, 1'b0);

      // Reset while the write sits in W_REG and the read in R_WAIT.
      REG_WWAT = 1'b1; REG_RWAT = 1'b1;
      drive_write(32'h50, 32'h5555_AAAA, 4'hF);
      S_ARADDR = 32'h14; S_ARVALID = 1'b1;
      tick();
      S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
      tick();
      chk("m_wstate_reg",  dbg_w, W_REG);
      chk("m_rstate_wait", dbg_r, R_WAIT);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("m_rst");
      idle_inputs();
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("m_post_awready", S_AWREADY, 1'b1);
      chk("m_post_wready",  S_WREADY,  1'b1);
      chk("m_post_arready", S_ARREADY, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("m_no_bvalid", S_BVALID, 1'b0);
         chk("m_no_rvalid", S_RVALID, 1'b0);
      end
      chk("m_wstate_idle", dbg_w, W_IDLE);
      chk("m_rstate_idle", dbg_r, R_IDLE);
      chk("exp_q_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sc_scbc_axi_regif
